// File: rtl/apb_sram_cfg.sv
// apb_sram_cfg: APB-attached single-port SRAM with configurable wait states,
// byte-lane strobes, an address range check and an optional protection check.
//
// Ports:
//   clk      - single clock; all logic on the rising edge
//   rstn     - synchronous active-low reset (memory contents are kept)
//   paddr    - byte address; the low log2(DW/8) bits are ignored
//   psel     - APB select
//   penable  - APB enable
//   pwrite   - APB write (1) / read (0)
//   pwdata   - write data, sampled on the completing edge
//   pstrb    - byte-lane write strobes, sampled on the completing edge
//   pprot    - protection type; bit 0 must be 1 when PROT_CHECK==1
//   pready   - registered transfer-complete
//   prdata   - registered read data, held between transfers
//   pslverr  - registered transfer error, only set while pready is high
module apb_sram_cfg #(
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned DW         = 32,
  parameter int unsigned RD_WAIT    = 0,
  parameter int unsigned WR_WAIT    = 0,
  parameter int unsigned PROT_CHECK = 0
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [ADDR_BITS+$clog2(DW/8)-1:0]    paddr,
  input  logic                                 psel,
  input  logic                                 penable,
  input  logic                                 pwrite,
  input  logic [DW-1:0]                        pwdata,
  input  logic [DW/8-1:0]                      pstrb,
  input  logic [2:0]                           pprot,
  output logic                                 pready,
  output logic [DW-1:0]                        prdata,
  output logic                                 pslverr
);

  localparam int unsigned NBYTE = DW / 8;
  localparam int unsigned LSB   = $clog2(NBYTE);
  localparam int unsigned PAW   = ADDR_BITS + LSB;
  localparam int unsigned CW    = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 wr_q, wr_d;
  logic                 err_q, err_d;
  logic                 pready_d;
  logic                 pslverr_d;
  logic                 rd_load_c;
  logic                 wr_en_c;

  logic [DW-1:0] mem [DEPTH];

  // Word address of the current bus cycle and its error classification.
  logic [ADDR_BITS-1:0] paddr_word_c;
  logic                 range_err_c;
  logic                 prot_err_c;

  assign paddr_word_c = paddr[PAW-1:LSB];
  assign range_err_c  = 32'(paddr_word_c) >= DEPTH;
  assign prot_err_c   = (PROT_CHECK != 0) && !pprot[0];

  // Byte-offset bits and upper protection bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{paddr[LSB-1:0], pprot[2:1]};

  // State and transfer-context registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // Next-state, wait counting and completion decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    err_d   = err_q;
    wr_en_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Only a genuine setup cycle starts a transfer; psel&penable here is ignored.
        if (psel && !penable) begin
          state_d = S_ACCESS;
          addr_d  = paddr_word_c;
          wr_d    = pwrite;
          err_d   = range_err_c || prot_err_c;
          cnt_d   = pwrite ? CW'(WR_WAIT) : CW'(RD_WAIT);
        end
      end
      S_ACCESS, S_WAIT: begin
        if (!psel) begin
          // Abort: drop the transfer without touching memory or prdata.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          wr_en_c = penable && wr_q && !err_q;
        end else begin
          state_d = S_WAIT;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // pready is registered, so decode it from the values the next cycle will hold.
    pready_d  = (state_d != S_IDLE) && (cnt_d == '0);
    pslverr_d = pready_d && err_d;
    rd_load_c = pready_d && !wr_d;
  end

  // Registered response outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      pready  <= pready_d;
      pslverr <= pslverr_d;
      if (rd_load_c) begin
        prdata <= err_d ? '0 : mem[addr_d];
      end
    end
  end

  // Storage array: no reset, and a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (rstn && wr_en_c) begin
      for (int i = 0; i < int'(NBYTE); i++) begin
        if (pstrb[i]) begin
          mem[addr_q][i*8 +: 8] <= pwdata[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_sram_cfg.sv
// tb_apb_sram_cfg: directed bench for apb_sram_cfg using two instances sharing
// one APB bus (separate psel): u_dut0 with defaults (no waits, DEPTH 1024) and
// u_dut1 with RD_WAIT=3, WR_WAIT=2, DEPTH=768, PROT_CHECK=1.
module tb_apb_sram_cfg;

  logic        clk;
  logic        rstn;
  logic [11:0] paddr;
  logic        psel0, psel1;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready0, pready1;
  logic [31:0] prdata0, prdata1;
  logic        pslverr0, pslverr1;

  int nvec = 0;
  int nerr = 0;

  apb_sram_cfg u_dut0 (
    .clk(clk), .rstn(rstn), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready0), .prdata(prdata0), .pslverr(pslverr0)
  );

  apb_sram_cfg #(
    .ADDR_BITS(10), .DEPTH(768), .DW(32),
    .RD_WAIT(3), .WR_WAIT(2), .PROT_CHECK(1)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .paddr(paddr), .psel(psel1), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready1), .prdata(prdata1), .pslverr(pslverr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete APB transfer starting at posedge+1; returns access cycles until pready.
  task automatic apb_xfer(input int d, input logic wr, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [2:0] prot, output int lat,
                          output logic [31:0] rdata, output logic err);
    logic rdy;
    psel0   = (d == 0);
    psel1   = (d == 1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    pprot   = prot;
    tick();
    penable = 1'b1;
    lat = 1;
    rdy = (d == 0) ? pready0 : pready1;
    while (!rdy && lat < 20) begin
      tick();
      lat++;
      rdy = (d == 0) ? pready0 : pready1;
    end
    rdata = (d == 0) ? prdata0 : prdata1;
    err   = (d == 0) ? pslverr0 : pslverr1;
    tick();
    psel0   = 1'b0;
    psel1   = 1'b0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    nvec++; if (pready0 !== 1'b0) begin nerr++; $display("FAIL reset_pready0 got %b exp 0", pready0); end
    nvec++; if (pslverr0 !== 1'b0) begin nerr++; $display("FAIL reset_pslverr0 got %b exp 0", pslverr0); end
    nvec++; if (prdata0 !== 32'h0) begin nerr++; $display("FAIL reset_prdata0 got %h exp 0", prdata0); end
    nvec++; if (pready1 !== 1'b0) begin nerr++; $display("FAIL reset_pready1 got %b exp 0", pready1); end
    nvec++; if (prdata1 !== 32'h0) begin nerr++; $display("FAIL reset_prdata1 got %h exp 0", prdata1); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er;
    apb_xfer(0, 1'b1, 12'h010, 32'hA5A5_1234, 4'hF, 3'b001, lat, rd, er);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL wr_latency got %0d exp 1", lat); end
    nvec++; if (er !== 1'b0) begin nerr++; $display("FAIL wr_pslverr got %b exp 0", er); end
    apb_xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 3'b001, lat, rd, er);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL rd_latency got %0d exp 1", lat); end
    nvec++; if (rd !== 32'hA5A5_1234) begin nerr++; $display("FAIL rd_data got %h exp a5a51234", rd); end
    nvec++; if (er !== 1'b0) begin nerr++; $display("FAIL rd_pslverr got %b exp 0", er); end
  endtask

  task automatic test_strobes();
    int lat; logic [31:0] rd; logic er;
    apb_xfer(0, 1'b1, 12'h010, 32'hFFFF_FFFF, 4'b0101, 3'b001, lat, rd, er);
    apb_xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 3'b001, lat, rd, er);
    nvec++; if (rd !== 32'hA5FF_12FF) begin nerr++; $display("FAIL strobe_data got %h exp a5ff12ff", rd); end
  endtask

  task automatic test_idle_enable();
    int lat; logic [31:0] rd; logic er;
    // psel & penable without a setup cycle must do nothing.
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h010;
    pwdata = 32'h0; pstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++; if (pready0 !== 1'b0) begin nerr++; $display("FAIL noset_pready cyc %0d got %b exp 0", i, pready0); end
    end
    psel0 = 1'b0; penable = 1'b0;
    tick();
    apb_xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 3'b001, lat, rd, er);
    nvec++; if (rd !== 32'hA5FF_12FF) begin nerr++; $display("FAIL noset_mem got %h exp a5ff12ff", rd); end
  endtask

  task automatic test_wait_states();
    int lat; logic [31:0] rd; logic er;
    apb_xfer(1, 1'b1, 12'h014, 32'h1122_3344, 4'hF, 3'b001, lat, rd, er);
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL wait_wr_latency got %0d exp 3", lat); end
    apb_xfer(1, 1'b0, 12'h014, 32'h0, 4'h0, 3'b001, lat, rd, er);
    nvec++; if (lat !== 4) begin nerr++; $display("FAIL wait_rd_latency got %0d exp 4", lat); end
    nvec++; if (rd !== 32'h1122_3344) begin nerr++; $display("FAIL wait_rd_data got %h exp 11223344", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    apb_xfer(1, 1'b1, 12'h080, 32'hCAFE_F00D, 4'hF, 3'b001, lat, rd, er);
    // Word 800 is beyond DEPTH 768; it aliases word 32 in the low address bits.
    apb_xfer(1, 1'b1, 12'hC80, 32'hDEAD_BEEF, 4'hF, 3'b001, lat, rd, er);
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL oor_wr_latency got %0d exp 3", lat); end
    nvec++; if (er !== 1'b1) begin nerr++; $display("FAIL oor_wr_pslverr got %b exp 1", er); end
    apb_xfer(1, 1'b0, 12'h080, 32'h0, 4'h0, 3'b001, lat, rd, er);
    nvec++; if (rd !== 32'hCAFE_F00D) begin nerr++; $display("FAIL oor_mem_intact got %h exp cafef00d", rd); end
    nvec++; if (er !== 1'b0) begin nerr++; $display("FAIL ok_rd_pslverr got %b exp 0", er); end
    apb_xfer(1, 1'b0, 12'h080, 32'h0, 4'h0, 3'b000, lat, rd, er);
    nvec++; if (er !== 1'b1) begin nerr++; $display("FAIL prot_pslverr got %b exp 1", er); end
    nvec++; if (rd !== 32'h0) begin nerr++; $display("FAIL prot_prdata got %h exp 0", rd); end
    nvec++; if (lat !== 4) begin nerr++; $display("FAIL prot_latency got %0d exp 4", lat); end
    apb_xfer(1, 1'b0, 12'h080, 32'h0, 4'h0, 3'b001, lat, rd, er);
    apb_xfer(1, 1'b0, 12'hE10, 32'h0, 4'h0, 3'b001, lat, rd, er);
    nvec++; if (er !== 1'b1 || rd !== 32'h0) begin nerr++; $display("FAIL oor_rd got err %b data %h exp err 1 data 0", er, rd); end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd; logic er;
    apb_xfer(1, 1'b1, 12'h018, 32'h55AA_55AA, 4'hF, 3'b001, lat, rd, er);
    apb_xfer(1, 1'b0, 12'h018, 32'h0, 4'h0, 3'b001, lat, rd, er);
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h018;
    pwdata = 32'h1234_5678; pstrb = 4'hF; pprot = 3'b001;
    tick();
    penable = 1'b1;
    tick();
    nvec++; if (pready1 !== 1'b0) begin nerr++; $display("FAIL abort_wait_pready got %b exp 0", pready1); end
    psel1 = 1'b0; penable = 1'b0;
    tick();
    nvec++; if (pready1 !== 1'b0) begin nerr++; $display("FAIL abort_pready got %b exp 0", pready1); end
    nvec++; if (prdata1 !== 32'h55AA_55AA) begin nerr++; $display("FAIL abort_prdata got %h exp 55aa55aa", prdata1); end
    tick();
    apb_xfer(1, 1'b0, 12'h018, 32'h0, 4'h0, 3'b001, lat, rd, er);
    nvec++; if (rd !== 32'h55AA_55AA) begin nerr++; $display("FAIL abort_mem got %h exp 55aa55aa", rd); end
    nvec++; if (lat !== 4) begin nerr++; $display("FAIL abort_next_latency got %0d exp 4", lat); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er;
    apb_xfer(0, 1'b1, 12'h100, 32'h0000_0001, 4'hF, 3'b001, lat, rd, er);
    apb_xfer(0, 1'b1, 12'h104, 32'h0000_0002, 4'hF, 3'b001, lat, rd, er);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL b2b_wr_latency got %0d exp 1", lat); end
    apb_xfer(0, 1'b0, 12'h100, 32'h0, 4'h0, 3'b001, lat, rd, er);
    nvec++; if (rd !== 32'h0000_0001 || lat !== 1) begin nerr++; $display("FAIL b2b_rd0 got %h lat %0d exp 00000001 lat 1", rd, lat); end
    apb_xfer(0, 1'b0, 12'h104, 32'h0, 4'h0, 3'b001, lat, rd, er);
    nvec++; if (rd !== 32'h0000_0002 || lat !== 1) begin nerr++; $display("FAIL b2b_rd1 got %h lat %0d exp 00000002 lat 1", rd, lat); end
    apb_xfer(1, 1'b1, 12'h040, 32'hBEEF_0001, 4'hF, 3'b001, lat, rd, er);
    apb_xfer(1, 1'b0, 12'h040, 32'h0, 4'h0, 3'b001, lat, rd, er);
    nvec++; if (rd !== 32'hBEEF_0001 || lat !== 4) begin nerr++; $display("FAIL b2b_wait_rd got %h lat %0d exp beef0001 lat 4", rd, lat); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er;
    apb_xfer(0, 1'b1, 12'h020, 32'h0BAD_CAFE, 4'hF, 3'b001, lat, rd, er);
    apb_xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 3'b001, lat, rd, er);
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020;
    pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    rstn = 1'b0;
    tick();
    nvec++; if (pready0 !== 1'b0) begin nerr++; $display("FAIL rstmid_pready got %b exp 0", pready0); end
    nvec++; if (prdata0 !== 32'h0) begin nerr++; $display("FAIL rstmid_prdata got %h exp 0", prdata0); end
    rstn = 1'b1; psel0 = 1'b0; penable = 1'b0;
    tick();
    apb_xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, 3'b001, lat, rd, er);
    nvec++; if (rd !== 32'h0BAD_CAFE) begin nerr++; $display("FAIL rstmid_mem got %h exp 0badcafe", rd); end
  endtask

  initial begin
    rstn = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001;
    test_reset();
    test_write_read();
    test_strobes();
    test_idle_enable();
    test_wait_states();
    test_errors();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
